// File: rtl/apb_pkg.sv
// Shared APB completer definitions: FSM state encodings, bus data width and
// the access-error check used when a request enters its access phase.
package apb_pkg;

  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_BAD    = 2'b11
  } apb_state_e;

  // Reject accesses that are not word-aligned or land past the last word.
  function automatic logic apb_access_err(input logic [1:0]  byte_off,
                                          input logic [31:0] word_idx,
                                          input logic [31:0] depth);
    return (byte_off != 2'b00) || (word_idx >= depth);
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Word-addressed register file: one synchronous write port, one combinational
// read port, all words cleared by the asynchronous active-low reset.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [APB_DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [APB_DATA_W-1:0] rd_data
);

  logic [APB_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/apb_slave.sv
// APB completer in front of a DEPTH x 32 register file: latches the request in
// SETUP, inserts WAIT_CYCLES wait states in ACCESS and flags bad addresses.
module apb_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  pclk_s,
  input  logic                  prst_s,
  input  logic                  psel_s,
  input  logic                  penable_s,
  input  logic                  pwrite_s,
  input  logic [ADDR_W-1:0]     paddress_s,
  input  logic [APB_DATA_W-1:0] pwdata_s,
  output logic [APB_DATA_W-1:0] prdata_s,
  output logic                  pready_s,
  output logic                  pslverr_s
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  write_q;
  logic [APB_DATA_W-1:0] wdata_q;
  logic                  err_q;
  logic [APB_DATA_W-1:0] prdata_q;
  logic                  latch_req;
  logic                  enter_access;
  logic                  commit;
  logic                  access_err;
  logic [IDX_W-1:0]      word_idx;
  logic [APB_DATA_W-1:0] rd_data;

  assign word_idx   = addr_q[IDX_W+1:2];
  assign access_err = apb_access_err(addr_q[1:0], 32'(addr_q[ADDR_W-1:2]), 32'(DEPTH));

  // Response is decoded purely from registered state so it never glitches with the bus.
  assign pready_s  = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
  assign pslverr_s = pready_s && err_q;
  assign prdata_s  = prdata_q;

  always_comb begin
    state_d      = ST_IDLE;
    latch_req    = 1'b0;
    enter_access = 1'b0;
    commit       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel_s && !penable_s) begin
          state_d   = ST_SETUP;
          latch_req = 1'b1;
        end
      end
      ST_SETUP: begin
        if (!psel_s) begin
          state_d = ST_IDLE;
        end else if (!penable_s) begin
          state_d   = ST_SETUP;
          latch_req = 1'b1;
        end else begin
          state_d      = ST_ACCESS;
          enter_access = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (pready_s) begin
          commit = write_q && !err_q;
          if (psel_s && !penable_s) begin
            state_d   = ST_SETUP;
            latch_req = 1'b1;
          end
        end else if (psel_s) begin
          state_d = ST_ACCESS;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk_s or negedge prst_s) begin
    if (!prst_s) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        addr_q  <= paddress_s;
        write_q <= pwrite_s;
        wdata_q <= pwdata_s;
      end
      if (enter_access) begin
        cnt_q <= 4'(WAIT_CYCLES);
        err_q <= access_err;
        if (!write_q) prdata_q <= access_err ? '0 : rd_data;
      end else if ((state_q == ST_ACCESS) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  apb_slave_regfile #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk     (pclk_s),
    .rst_n   (prst_s),
    .we      (commit),
    .wr_idx  (word_idx),
    .wr_data (wdata_q),
    .rd_idx  (word_idx),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave: three instances (WAIT_CYCLES 0, 3, 2) share one
// bus, with psel routed to the instance selected by sel.
module tb_apb_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [1:0]  sel;

  logic [2:0]  psel_v;
  logic [31:0] prdata_v  [3];
  logic        pready_v  [3];
  logic        pslverr_v [3];
  logic [31:0] prdata;
  logic        pready, pslverr;

  logic [31:0] rd;
  logic        err;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          highs;

  always #5 clk = ~clk;

  assign psel_v[0] = psel && (sel == 2'd0);
  assign psel_v[1] = psel && (sel == 2'd1);
  assign psel_v[2] = psel && (sel == 2'd2);

  always_comb begin
    prdata  = prdata_v[sel];
    pready  = pready_v[sel];
    pslverr = pslverr_v[sel];
  end

  apb_slave #(.ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(0)) u_w0 (
    .pclk_s(clk), .prst_s(rst_n), .psel_s(psel_v[0]), .penable_s(penable),
    .pwrite_s(pwrite), .paddress_s(paddr), .pwdata_s(pwdata),
    .prdata_s(prdata_v[0]), .pready_s(pready_v[0]), .pslverr_s(pslverr_v[0]));

  apb_slave #(.ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(3)) u_w3 (
    .pclk_s(clk), .prst_s(rst_n), .psel_s(psel_v[1]), .penable_s(penable),
    .pwrite_s(pwrite), .paddress_s(paddr), .pwdata_s(pwdata),
    .prdata_s(prdata_v[1]), .pready_s(pready_v[1]), .pslverr_s(pslverr_v[1]));

  apb_slave #(.ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(2)) u_w2 (
    .pclk_s(clk), .prst_s(rst_n), .psel_s(psel_v[2]), .penable_s(penable),
    .pwrite_s(pwrite), .paddress_s(paddr), .pwdata_s(pwdata),
    .prdata_s(prdata_v[2]), .pready_s(pready_v[2]), .pslverr_s(pslverr_v[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One full transfer; keep leaves psel high after completion for back-to-back use.
  task automatic xfer(input string tag, input logic wr, input logic [7:0] a,
                      input logic [31:0] d, input logic keep, input int exp_waits,
                      output logic [31:0] rdat, output logic rerr);
    int waits;
    bit done;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    waits = 0; done = 1'b0; rdat = '0; rerr = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (pready) begin
        done = 1'b1; rdat = prdata; rerr = pslverr;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " waits"}, 32'(waits), 32'(exp_waits));
    penable = 1'b0;
    if (!keep) psel = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset prdata", prdata, 32'h0);
    check("reset pready", 32'(pready), 32'd0);
    check("reset pslverr", 32'(pslverr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer("wr04", 1'b1, 8'h04, 32'hDEADBEEF, 1'b0, 0, rd, err);
    check("wr04 err", 32'(err), 32'd0);
    xfer("rd04", 1'b0, 8'h04, 32'h0, 1'b0, 0, rd, err);
    check("rd04 data", rd, 32'hDEADBEEF);
    check("rd04 err", 32'(err), 32'd0);

    xfer("wr41", 1'b1, 8'h41, 32'h12345678, 1'b0, 0, rd, err);
    check("wr41 err", 32'(err), 32'd1);
    check("wr41 prdata held", rd, 32'hDEADBEEF);
    xfer("wr05", 1'b1, 8'h05, 32'h55555555, 1'b0, 0, rd, err);
    check("wr05 err", 32'(err), 32'd1);
    xfer("rd04b", 1'b0, 8'h04, 32'h0, 1'b0, 0, rd, err);
    check("rd04b data", rd, 32'hDEADBEEF);
    xfer("rd40", 1'b0, 8'h40, 32'h0, 1'b0, 0, rd, err);
    check("rd40 err", 32'(err), 32'd1);
    check("rd40 data", rd, 32'h0);
    xfer("rd00", 1'b0, 8'h00, 32'h0, 1'b0, 0, rd, err);
    check("rd00 untouched", rd, 32'h0);

    xfer("b2b0", 1'b1, 8'h00, 32'h11111111, 1'b1, 0, rd, err);
    check("b2b0 err", 32'(err), 32'd0);
    xfer("b2b1", 1'b1, 8'h0C, 32'h0C0C0C0C, 1'b0, 0, rd, err);
    check("b2b1 err", 32'(err), 32'd0);
    xfer("rdb0", 1'b0, 8'h00, 32'h0, 1'b0, 0, rd, err);
    check("rdb0 data", rd, 32'h11111111);
    xfer("rdb1", 1'b0, 8'h0C, 32'h0, 1'b0, 0, rd, err);
    check("rdb1 data", rd, 32'h0C0C0C0C);

    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'hA5A5A5A5;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst pre pready", 32'(pready), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst prdata", prdata, 32'h0);
    check("rst pready", 32'(pready), 32'd0);
    check("rst pslverr", 32'(pslverr), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    xfer("rd10", 1'b0, 8'h10, 32'h0, 1'b0, 0, rd, err);
    check("rd10 data", rd, 32'h0);
    xfer("rd0c", 1'b0, 8'h0C, 32'h0, 1'b0, 0, rd, err);
    check("rd0c cleared", rd, 32'h0);

    sel = 2'd1;
    xfer("w3rd08", 1'b0, 8'h08, 32'h0, 1'b0, 3, rd, err);
    check("w3rd08 data", rd, 32'h0);
    check("w3rd08 err", 32'(err), 32'd0);
    xfer("w3wr08", 1'b1, 8'h08, 32'h87654321, 1'b0, 3, rd, err);
    xfer("w3rd08b", 1'b0, 8'h08, 32'h0, 1'b0, 3, rd, err);
    check("w3rd08b data", rd, 32'h87654321);

    sel = 2'd2;
    xfer("w2wr08", 1'b1, 8'h08, 32'h22222222, 1'b0, 2, rd, err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h33333333;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort pready early", 32'(pready), 32'd0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    highs = 0;
    repeat (6) begin
      @(negedge clk);
      if (pready) highs++;
    end
    check("abort pready rose", 32'(highs), 32'd0);
    xfer("w2rd08", 1'b0, 8'h08, 32'h0, 1'b0, 2, rd, err);
    check("w2rd08 data", rd, 32'h22222222);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
